arx_conv2d_dram_arbiter: RTL

Two-requester AXI arbiter that shares the single AXI slave port of the conv2d slow-DRAM model between two masters, e.g. the conv2d input/weight fetcher and the output writer. Read and write directions are arbitrated independently. Each direction locks onto one transaction and holds it until that transaction completes, so there is exactly one outstanding read and one outstanding write downstream. IDs pass through unchanged.

---
 rtl/arx_conv2d_dram_arbiter_pkg.sv | 22 ++
 rtl/arx_conv2d_dram_arb_lock.sv | 73 +++++++
 rtl/arx_conv2d_dram_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/arx_conv2d_dram_arbiter_pkg.sv
// Shared definitions for the conv2d slow-DRAM two-requester AXI arbiter.
package arx_conv2d_dram_arbiter_pkg;

  // Number of upstream AXI masters sharing the DRAM model port.
  localparam int unsigned NUM_REQ = 2;

  // Write direction: address, data burst, then response.
  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wstate_e;

  // Read direction: address, then data burst (response rides on R).
  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rstate_e;

endpackage

// File: rtl/arx_conv2d_dram_arb_lock.sv
// Grant core for one arbitration direction: picks an owner from the request
// vector while idle, holds it until the done pulse, then releases.
// Build option: ARX_CONV2D_DRAM_ARB_RR_EN selects round-robin over fixed s0 priority.
module arx_conv2d_dram_arb_lock
  import arx_conv2d_dram_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rstnn,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_done,
  output logic [NUM_REQ-1:0] o_grant,
  output logic               o_busy
);

  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] w_grant_nxt;
  logic [NUM_REQ-1:0] w_pick;
  logic               w_take;

  assign o_grant = r_grant;
  assign o_busy  = |r_grant;
  assign w_take  = !o_busy && (|i_req);

`ifdef ARX_CONV2D_DRAM_ARB_RR_EN
  // Index of the requester served last; reset value 1 lets s0 win first.
  logic r_last;

  // Winner selection: on a tie the requester not served last wins.
  always_comb begin
    w_pick = i_req;
    if (i_req == 2'b11) begin
      w_pick = r_last ? 2'b01 : 2'b10;
    end
  end

  // Last-served pointer, updated when a grant is taken.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_last <= 1'b1;
    end else if (w_take) begin
      r_last <= w_pick[1];
    end
  end
`else
  // Winner selection: fixed priority, s0 over s1.
  always_comb begin
    w_pick = i_req;
    if (i_req[0]) begin
      w_pick = 2'b01;
    end
  end
`endif

  // Next grant: lock a winner while idle, release on completion.
  always_comb begin
    w_grant_nxt = r_grant;
    if (w_take) begin
      w_grant_nxt = w_pick;
    end else if (o_busy && i_done) begin
      w_grant_nxt = '0;
    end
  end

  // Grant register.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_grant <= '0;
    end else begin
      r_grant <= w_grant_nxt;
    end
  end

endmodule

// File: rtl/arx_conv2d_dram_arbiter.sv
// Two-requester AXI arbiter in front of the conv2d slow-DRAM model. Read and
// write are locked independently, one transaction each, IDs passed through.
// Build option: ARX_CONV2D_DRAM_ARB_RR_EN (round-robin); default is fixed s0 priority.
`ifndef BW_AXI_WSTRB
`define BW_AXI_WSTRB(bw) ((bw) / 8)
`endif

module arx_conv2d_dram_arbiter
  import arx_conv2d_dram_arbiter_pkg::*;
#(
  parameter int BW_ADDR    = 32,
  parameter int BW_DATA    = 32,
  parameter int BW_AXI_TID = 16
) (
  input  logic                             clk,
  input  logic                             rstnn,
  // requester 0
  input  logic [BW_AXI_TID-1:0]            s0awid,
  input  logic [BW_ADDR-1:0]               s0awaddr,
  input  logic [7:0]                       s0awlen,
  input  logic [2:0]                       s0awsize,
  input  logic [1:0]                       s0awburst,
  input  logic                             s0awvalid,
  output logic                             s0awready,
  input  logic [BW_AXI_TID-1:0]            s0wid,
  input  logic [BW_DATA-1:0]               s0wdata,
  input  logic [`BW_AXI_WSTRB(BW_DATA)-1:0] s0wstrb,
  input  logic                             s0wlast,
  input  logic                             s0wvalid,
  output logic                             s0wready,
  output logic [BW_AXI_TID-1:0]            s0bid,
  output logic [1:0]                       s0bresp,
  output logic                             s0bvalid,
  input  logic                             s0bready,
  input  logic [BW_AXI_TID-1:0]            s0arid,
  input  logic [BW_ADDR-1:0]               s0araddr,
  input  logic [7:0]                       s0arlen,
  input  logic [2:0]                       s0arsize,
  input  logic [1:0]                       s0arburst,
  input  logic                             s0arvalid,
  output logic                             s0arready,
  output logic [BW_AXI_TID-1:0]            s0rid,
  output logic [BW_DATA-1:0]               s0rdata,
  output logic [1:0]                       s0rresp,
  output logic                             s0rlast,
  output logic                             s0rvalid,
  input  logic                             s0rready,
  // requester 1
  input  logic [BW_AXI_TID-1:0]            s1awid,
  input  logic [BW_ADDR-1:0]               s1awaddr,
  input  logic [7:0]                       s1awlen,
  input  logic [2:0]                       s1awsize,
  input  logic [1:0]                       s1awburst,
  input  logic                             s1awvalid,
  output logic                             s1awready,
  input  logic [BW_AXI_TID-1:0]            s1wid,
  input  logic [BW_DATA-1:0]               s1wdata,
  input  logic [`BW_AXI_WSTRB(BW_DATA)-1:0] s1wstrb,
  input  logic                             s1wlast,
  input  logic                             s1wvalid,
  output logic                             s1wready,
  output logic [BW_AXI_TID-1:0]            s1bid,
  output logic [1:0]                       s1bresp,
  output logic                             s1bvalid,
  input  logic                             s1bready,
  input  logic [BW_AXI_TID-1:0]            s1arid,
  input  logic [BW_ADDR-1:0]               s1araddr,
  input  logic [7:0]                       s1arlen,
  input  logic [2:0]                       s1arsize,
  input  logic [1:0]                       s1arburst,
  input  logic                             s1arvalid,
  output logic                             s1arready,
  output logic [BW_AXI_TID-1:0]            s1rid,
  output logic [BW_DATA-1:0]               s1rdata,
  output logic [1:0]                       s1rresp,
  output logic                             s1rlast,
  output logic                             s1rvalid,
  input  logic                             s1rready,
  // downstream DRAM model port
  output logic [BW_AXI_TID-1:0]            mxawid,
  output logic [BW_ADDR-1:0]               mxawaddr,
  output logic [7:0]                       mxawlen,
  output logic [2:0]                       mxawsize,
  output logic [1:0]                       mxawburst,
  output logic                             mxawvalid,
  input  logic                             mxawready,
  output logic [BW_AXI_TID-1:0]            mxwid,
  output logic [BW_DATA-1:0]               mxwdata,
  output logic [`BW_AXI_WSTRB(BW_DATA)-1:0] mxwstrb,
  output logic                             mxwlast,
  output logic                             mxwvalid,
  input  logic                             mxwready,
  input  logic [BW_AXI_TID-1:0]            mxbid,
  input  logic [1:0]                       mxbresp,
  input  logic                             mxbvalid,
  output logic                             mxbready,
  output logic [BW_AXI_TID-1:0]            mxarid,
  output logic [BW_ADDR-1:0]               mxaraddr,
  output logic [7:0]                       mxarlen,
  output logic [2:0]                       mxarsize,
  output logic [1:0]                       mxarburst,
  output logic                             mxarvalid,
  input  logic                             mxarready,
  input  logic [BW_AXI_TID-1:0]            mxrid,
  input  logic [BW_DATA-1:0]               mxrdata,
  input  logic [1:0]                       mxrresp,
  input  logic                             mxrlast,
  input  logic                             mxrvalid,
  output logic                             mxrready,
  // ownership
  output logic [NUM_REQ-1:0]               wgrant,
  output logic [NUM_REQ-1:0]               rgrant
);

  wstate_e            r_wstate, w_wstate_nxt;
  rstate_e            r_rstate, w_rstate_nxt;
  logic [NUM_REQ-1:0] w_wreq, w_rreq;
  logic               w_wdone, w_rdone;
  logic               w_wbusy, w_rbusy;
  logic               w_wsel, w_rsel;

  assign w_wreq  = {s1awvalid, s0awvalid};
  assign w_rreq  = {s1arvalid, s0arvalid};
  assign w_wsel  = wgrant[1];
  assign w_rsel  = rgrant[1];
  assign w_wdone = (r_wstate == W_RESP) && mxbvalid && mxbready;
  assign w_rdone = (r_rstate == R_DATA) && mxrvalid && mxrready && mxrlast;

  arx_conv2d_dram_arb_lock u_wlock (
    .clk     (clk),
    .rstnn   (rstnn),
    .i_req   (w_wreq),
    .i_done  (w_wdone),
    .o_grant (wgrant),
    .o_busy  (w_wbusy)
  );

  arx_conv2d_dram_arb_lock u_rlock (
    .clk     (clk),
    .rstnn   (rstnn),
    .i_req   (w_rreq),
    .i_done  (w_rdone),
    .o_grant (rgrant),
    .o_busy  (w_rbusy)
  );

  // Write phase register.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_wstate <= W_IDLE;
    end else begin
      r_wstate <= w_wstate_nxt;
    end
  end

  // Write phase sequencing; IDLE->ADDR coincides with the lock taking a grant.
  always_comb begin
    w_wstate_nxt = r_wstate;
    unique case (r_wstate)
      W_IDLE: if (|w_wreq) w_wstate_nxt = W_ADDR;
      W_ADDR: if (mxawvalid && mxawready) w_wstate_nxt = W_DATA;
      W_DATA: if (mxwvalid && mxwready && mxwlast) w_wstate_nxt = W_RESP;
      W_RESP: if (w_wdone) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Write channel routing; everything not owned and routed is held at 0.
  always_comb begin
    mxawid = '0; mxawaddr = '0; mxawlen = '0; mxawsize = '0; mxawburst = '0;
    mxawvalid = 1'b0;
    mxwid = '0; mxwdata = '0; mxwstrb = '0; mxwlast = 1'b0; mxwvalid = 1'b0;
    mxbready = 1'b0;
    s0awready = 1'b0; s1awready = 1'b0;
    s0wready = 1'b0; s1wready = 1'b0;
    s0bid = '0; s0bresp = '0; s0bvalid = 1'b0;
    s1bid = '0; s1bresp = '0; s1bvalid = 1'b0;
    unique case (r_wstate)
      W_ADDR: begin
        if (w_wsel) begin
          mxawid = s1awid; mxawaddr = s1awaddr; mxawlen = s1awlen;
          mxawsize = s1awsize; mxawburst = s1awburst; mxawvalid = s1awvalid;
          s1awready = mxawready;
        end else begin
          mxawid = s0awid; mxawaddr = s0awaddr; mxawlen = s0awlen;
          mxawsize = s0awsize; mxawburst = s0awburst; mxawvalid = s0awvalid;
          s0awready = mxawready;
        end
      end
      W_DATA: begin
        if (w_wsel) begin
          mxwid = s1wid; mxwdata = s1wdata; mxwstrb = s1wstrb;
          mxwlast = s1wlast; mxwvalid = s1wvalid;
          s1wready = mxwready;
        end else begin
          mxwid = s0wid; mxwdata = s0wdata; mxwstrb = s0wstrb;
          mxwlast = s0wlast; mxwvalid = s0wvalid;
          s0wready = mxwready;
        end
      end
      W_RESP: begin
        if (w_wsel) begin
          s1bid = mxbid; s1bresp = mxbresp; s1bvalid = mxbvalid;
          mxbready = s1bready;
        end else begin
          s0bid = mxbid; s0bresp = mxbresp; s0bvalid = mxbvalid;
          mxbready = s0bready;
        end
      end
      default: ;
    endcase
  end

  // Read phase register.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_rstate <= R_IDLE;
    end else begin
      r_rstate <= w_rstate_nxt;
    end
  end

  // Read phase sequencing.
  always_comb begin
    w_rstate_nxt = r_rstate;
    unique case (r_rstate)
      R_IDLE: if (|w_rreq) w_rstate_nxt = R_ADDR;
      R_ADDR: if (mxarvalid && mxarready) w_rstate_nxt = R_DATA;
      R_DATA: if (w_rdone) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Read channel routing; everything not owned and routed is held at 0.
  always_comb begin
    mxarid = '0; mxaraddr = '0; mxarlen = '0; mxarsize = '0; mxarburst = '0;
    mxarvalid = 1'b0;
    mxrready = 1'b0;
    s0arready = 1'b0; s1arready = 1'b0;
    s0rid = '0; s0rdata = '0; s0rresp = '0; s0rlast = 1'b0; s0rvalid = 1'b0;
    s1rid = '0; s1rdata = '0; s1rresp = '0; s1rlast = 1'b0; s1rvalid = 1'b0;
    unique case (r_rstate)
      R_ADDR: begin
        if (w_rsel) begin
          mxarid = s1arid; mxaraddr = s1araddr; mxarlen = s1arlen;
          mxarsize = s1arsize; mxarburst = s1arburst; mxarvalid = s1arvalid;
          s1arready = mxarready;
        end else begin
          mxarid = s0arid; mxaraddr = s0araddr; mxarlen = s0arlen;
          mxarsize = s0arsize; mxarburst = s0arburst; mxarvalid = s0arvalid;
          s0arready = mxarready;
        end
      end
      R_DATA: begin
        if (w_rsel) begin
          s1rid = mxrid; s1rdata = mxrdata; s1rresp = mxrresp;
          s1rlast = mxrlast; s1rvalid = mxrvalid;
          mxrready = s1rready;
        end else begin
          s0rid = mxrid; s0rdata = mxrdata; s0rresp = mxrresp;
          s0rlast = mxrlast; s0rvalid = mxrvalid;
          mxrready = s0rready;
        end
      end
      default: ;
    endcase
  end

endmodule
